// File: rtl/div_controller_pkg.sv
// -----------------------------------------------------------------------------
// div_controller_pkg
//   Shared definitions for the execute-stage divide controller.
//   - ALU_SIGNED_DIV / ALU_UNSIGNED_DIV : decoded ALU control codes for DIV/DIVU
//   - div_state_e                       : 2-bit FSM encoding (DIV_IDLE/BUSY/DONE)
//   - cond_neg()                        : two's-complement negate when asked
// -----------------------------------------------------------------------------
package div_controller_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [4:0] ALU_SIGNED_DIV   = 5'b01110;
   localparam logic [4:0] ALU_UNSIGNED_DIV = 5'b01111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   // Wraps modulo 2^32, so -(0x80000000) stays 0x80000000 (signed overflow case).
   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
//   One combinational radix-2 restoring-division step.
//   {rem, quo} is shifted left by one; if the 33-bit partial remainder is at
//   least the divisor, the divisor is subtracted and a quotient 1 is shifted in.
//   Ports:
//     i_rem     [WIDTH-1:0] : partial remainder before the step
//     i_quo     [WIDTH-1:0] : remaining dividend bits / quotient so far
//     i_divisor [WIDTH-1:0] : divisor magnitude
//     o_rem     [WIDTH-1:0] : partial remainder after the step
//     o_quo     [WIDTH-1:0] : quotient register after the step
// -----------------------------------------------------------------------------
module div_iter
   import div_controller_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, i_divisor});
   // The incoming remainder is always below the divisor, so a successful
   // subtraction result fits in WIDTH bits and the carry bit can be dropped.
   assign w_diff   = w_rem_sh[WIDTH-1:0] - i_divisor;
   assign o_rem    = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
   assign o_quo    = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_controller.sv
// -----------------------------------------------------------------------------
// div_controller
//   Multi-cycle DIV/DIVU controller for the EX stage. Runs 32 restoring
//   iterations (one per cycle), holds the pipeline while busy and presents
//   quotient (div_lo) and remainder (div_hi) for the HI/LO write.
//   Optional feature macro: DIV_EARLY_EXIT_EN -- when defined, a zero divisor or
//   |a| < |b| skips the iterations and goes straight to DONE.
//   Ports:
//     clk, resetn            : clock, asynchronous active-low reset
//     alu_controlE [4:0]     : decoded ALU control of the EX instruction
//     src_aE / src_bE [31:0] : dividend / divisor
//     flushE                 : cancels any divide, back to IDLE next edge
//     pipe_stall             : EX held elsewhere; keeps the result in DONE
//     div_stallE             : hold IF/ID/EX (start cycle and BUSY)
//     div_valid              : div_hi/div_lo hold the final result (DONE)
//     div_hi / div_lo [31:0] : remainder / quotient
//     o_dbg_state            : current FSM state
//   Handshake: div_valid/div_hi/div_lo stay stable for as long as DONE is held;
//   the result counts as consumed on the first DONE cycle with pipe_stall=0.
// -----------------------------------------------------------------------------
module div_controller
   import div_controller_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [4:0]       alu_controlE,
   input  logic [WIDTH-1:0] src_aE,
   input  logic [WIDTH-1:0] src_bE,
   input  logic             flushE,
   input  logic             pipe_stall,
   output logic             div_stallE,
   output logic             div_valid,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo,
   output div_state_e       o_dbg_state
);

   div_state_e       r_state;
   div_state_e       w_next_state;
   logic [4:0]       r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_dividend;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_dz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_signed;
   logic             w_start;
   logic             w_early;
   logic             w_last;
   logic             w_stall;
   logic             w_valid;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH-1:0] w_iter_rem;
   logic [WIDTH-1:0] w_iter_quo;

   assign w_signed = (alu_controlE == ALU_SIGNED_DIV);
   assign w_start  = ((alu_controlE == ALU_SIGNED_DIV) ||
                      (alu_controlE == ALU_UNSIGNED_DIV)) && !flushE;
   assign w_mag_a  = cond_neg(src_aE, w_signed & src_aE[WIDTH-1]);
   assign w_mag_b  = cond_neg(src_bE, w_signed & src_bE[WIDTH-1]);
   assign w_last   = (r_cnt == 5'd31);

`ifdef DIV_EARLY_EXIT_EN
   assign w_early = (src_bE == '0) || (w_mag_a < w_mag_b);
`else
   assign w_early = 1'b0;
`endif

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem     (w_iter_rem),
      .o_quo     (w_iter_quo)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state and outputs ----------------
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_valid      = 1'b0;
      unique case (r_state)
         DIV_IDLE: begin
            w_stall = w_start;
            if (w_start) begin
               w_next_state = w_early ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            w_stall = 1'b1;
            if (w_last) begin
               w_next_state = DIV_DONE;
            end
         end
         DIV_DONE: begin
            w_valid = 1'b1;
            if (!pipe_stall) begin
               w_next_state = DIV_IDLE;
            end
         end
         default: begin
            w_next_state = DIV_IDLE;
         end
      endcase
      if (flushE) begin
         w_next_state = DIV_IDLE;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_divisor  <= '0;
         r_dividend <= '0;
         r_qneg     <= 1'b0;
         r_rneg     <= 1'b0;
         r_dz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else if (flushE) begin
         r_cnt <= '0;
      end else begin
         unique case (r_state)
            DIV_IDLE: begin
               if (w_start) begin
                  r_cnt      <= '0;
                  r_rem      <= '0;
                  r_quo      <= w_mag_a;
                  r_divisor  <= w_mag_b;
                  r_dividend <= src_aE;
                  r_qneg     <= w_signed & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                  r_rneg     <= w_signed & src_aE[WIDTH-1];
                  r_dz       <= (src_bE == '0);
                  // Early exit: quotient 0 / remainder a, or the divide-by-zero
                  // pattern; the raw dividend already carries the right sign.
                  if (w_early) begin
                     r_hi <= src_aE;
                     r_lo <= (src_bE == '0) ? '1 : '0;
                  end
               end
            end
            DIV_BUSY: begin
               r_rem <= w_iter_rem;
               r_quo <= w_iter_quo;
               r_cnt <= r_cnt + 5'd1;
               // The sign fix is folded into the final iteration edge so the
               // result registers are already corrected throughout DONE.
               if (w_last) begin
                  r_hi <= r_dz ? r_dividend : cond_neg(w_iter_rem, r_rneg);
                  r_lo <= r_dz ? '1         : cond_neg(w_iter_quo, r_qneg);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign div_stallE  = w_stall;
   assign div_valid   = w_valid;
   assign div_hi      = r_hi;
   assign div_lo      = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: doc/div_controller.md
# div_controller

Multi-cycle divide controller for the execute stage. It detects `ALU_SIGNED_DIV` / `ALU_UNSIGNED_DIV` on the decoded ALU control and runs a 32-iteration radix-2 restoring division. While the division runs it stalls the pipeline, then presents quotient and remainder for the HI/LO write. It sits beside the single-cycle ALU in EX and is the only block that holds EX for a divide.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `alu_controlE`  in  5: decoded ALU control of the instruction in EX.
- `src_aE`  in  32: dividend (rs).
- `src_bE`  in  32: divisor (rt).
- `flushE`  in  1: exception/flush of EX; cancels any divide.
- `pipe_stall`  in  1: EX held by another source (e.g. memory); result not yet consumed.
- `div_stallE`  out  1: request to hold IF/ID/EX.
- `div_valid`  out  1: `div_hi` / `div_lo` hold the final result.
- `div_hi`  out  32: remainder.
- `div_lo`  out  32: quotient.

## Operation
- `start` = (`alu_controlE` == `ALU_SIGNED_DIV` or `ALU_UNSIGNED_DIV`) & ~`flushE`.
- States:
  - IDLE: on `start`, latch the signedness flag and the operand magnitudes. Magnitudes are the absolute value when signed, raw when unsigned. Also latch the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), both only when signed. Clear the iteration counter and go to BUSY.
  - BUSY: one iteration per cycle. The 64-bit {rem, quo} shifts left by 1. If rem[32:0] >= {1'b0, divisor}, subtract the divisor and set quo[0]. After iteration 32 (counter 31 → wrap), go to DONE.
  - DONE: apply the sign fix. Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set. `div_valid`=1. Go to IDLE when `pipe_stall`=0; otherwise hold DONE with the result stable.
- `div_stallE` = (IDLE & `start`) | BUSY. It is combinational and is 0 in DONE, so EX can advance with the result.
- Divide by zero is handled as a special case, latched in IDLE: `div_hi` = `src_aE` as given, `div_lo` = 32'hFFFFFFFF, for both DIV and DIVU. The divide still takes the full latency unless early exit is compiled in.
- Signed overflow: 0x80000000 / -1 gives lo = 0x80000000, hi = 0. This falls out of 32-bit negation wraparound.
- `flushE` in any state forces IDLE on the next edge, with no `div_valid`. If `flushE` arrives in the same cycle as a divide opcode, no start occurs.
- The DONE→IDLE transition needs `pipe_stall`=0, which means EX has advanced. The same instruction is therefore never restarted.
- Reset values: state IDLE, counter 0, `div_valid` 0, `div_hi` 0, `div_lo` 0, `div_stallE` 0.
- Reset mid-operation aborts immediately and produces no output.

## Timing
- The start is seen in cycle 0. BUSY runs in cycles 1–32. DONE with `div_valid`=1 is in cycle 33 (full latency 33).
- `div_stallE` is high in cycles 0–32 and low in cycle 33.
- `div_valid` lasts exactly 1 cycle if `pipe_stall`=0; otherwise it lasts until the first cycle with `pipe_stall`=0, inclusive.
- A new divide can start in the cycle after DONE exits.

## Configuration
- `DIV_EARLY_EXIT_EN` defined: in IDLE, if the divisor is 0 or |a| < |b| (unsigned magnitude compare), go straight to DONE. `div_valid` then rises in cycle 1 and `div_stallE` is high only in cycle 0.
  - |a| < |b| gives quotient 0 and remainder a.
  - Divisor 0 gives the divide-by-zero result above.
- `DIV_EARLY_EXIT_EN` undefined: every divide takes 33 cycles.

## Structure
- `ALU_SIGNED_DIV` and `ALU_UNSIGNED_DIV` come from the shared `aludefines.vh`. Add the state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2 bits) to the same header.
- One sub-module, `div_iter`: a combinational single iteration, (rem, quo, divisor) → (rem', quo'). The FSM, counter, sign handling and registers stay in `div_controller`.

## Test plan
- DIVU 100/7, `pipe_stall`=0 → `div_valid` at cycle 33, lo=14, hi=2; `div_stallE` high for cycles 0–32.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- `flushE` pulsed in cycle 10 of a divide → state IDLE in cycle 11, `div_stallE`=0, no `div_valid`. A new DIVU 9/3 starting in cycle 12 yields lo=3, hi=0.
- `pipe_stall` high for cycles 33–35 → `div_valid` is high in cycles 33–36 with the result unchanged and `div_stallE`=0. No restart occurs in cycle 37.
- With `DIV_EARLY_EXIT_EN`: DIVU 3/5 → `div_valid` at cycle 1, lo=0, hi=3. Without it, the same divide gives `div_valid` at cycle 33.
